// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the mouse over the
// shared open-drain clock/data pair and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 13000,
  parameter int unsigned SETUP_CYCLES   = 130,
  parameter int unsigned TIMEOUT_CYCLES = 2600000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned MAX_A      = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic          cur_bit_q, cur_bit_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    err_code_q, err_code_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  logic fall;
  logic timed;
  logic timeout_hit;

  // Lines idle high, so the synchronizers reset to 1 to avoid a phantom fall edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      cur_bit_q  <= 1'b1;
      bit_cnt_q  <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      cur_bit_q  <= cur_bit_d;
      bit_cnt_q  <= bit_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign fall        = clk_prev_q & ~clk_sync_q;
  assign timed       = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign timeout_hit = timed && !fall && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    cur_bit_d     = cur_bit_q;
    bit_cnt_d     = bit_cnt_q;
    err_code_d    = err_code_q;
    tx_ready_o    = 1'b0;
    busy_o        = 1'b1;
    ps2_clk_oe_o  = 1'b0;
    ps2_data_oe_o = 1'b0;
    tx_done_o     = 1'b0;
    tx_err_o      = 1'b0;
    err_code_o    = err_code_q;

    case (state_q)
      S_IDLE: begin
        tx_ready_o = 1'b1;
        busy_o     = 1'b0;
        cnt_d      = '0;
        bit_cnt_d  = '0;
        if (tx_valid_i) begin
          shift_d   = {~^tx_data_i, tx_data_i};
          cur_bit_d = 1'b0;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_START: begin
        ps2_clk_oe_o  = 1'b1;
        ps2_data_oe_o = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          cnt_d     = '0;
          cur_bit_d = 1'b0;
          state_d   = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SHIFT: begin
        // cur_bit_q starts as the start bit and holds it until the first device fall.
        ps2_data_oe_o = ~cur_bit_q;
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            cur_bit_d = 1'b1;
            state_d   = S_ACK;
          end else begin
            cur_bit_d = shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end
        end
      end

      S_ACK: begin
        if (fall) begin
          if (data_sync_q) begin
            tx_err_o   = 1'b1;
            err_code_o = ERR_NACK;
            err_code_d = ERR_NACK;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          tx_done_o = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timed) begin
      cnt_d = fall ? '0 : cnt_q + CNT_ONE;
    end

    // Timeout overrides everything, including a done in the same cycle.
    if (timeout_hit) begin
      state_d       = S_IDLE;
      ps2_clk_oe_o  = 1'b0;
      ps2_data_oe_o = 1'b0;
      tx_done_o     = 1'b0;
      tx_err_o      = 1'b1;
      err_code_o    = ERR_TIMEOUT;
      err_code_d    = ERR_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and checks bits, parity, ACK handling, timeout and reset behaviour.
module tb_ps2_host_tx;

  localparam int INH   = 40;
  localparam int SETUP = 10;
  localparam int TO    = 600;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       clk_oe, data_oe;
  logic       busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~clk_oe;
  assign ps2_data_line = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SETUP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_data_i   (ps2_data_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe),
    .busy_o       (busy),
    .tx_done_o    (tx_done),
    .tx_err_o     (tx_err),
    .err_code_o   (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  logic       pend = 1'b0;
  logic       ready_after = 1'b0;
  logic       last_oe = 1'b0;

  always @(negedge clk) begin
    pend <= tx_done | tx_err;
    if (pend) ready_after <= tx_ready;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt <= err_cnt + 1;
      last_oe <= clk_oe | data_oe;
    end
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    int         exp_done;
    int         exp_err;
    logic [1:0] exp_code;
  } vec_t;

  typedef struct {
    int         inh;
    int         setup;
    logic       start;
    logic [9:0] bits;
    int         dd;
    int         de;
    logic       idle_to;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic begin_tx(input logic drive, input logic [7:0] d, input logic keep,
                          input logic [7:0] nd, output int inh, output int setup);
    if (drive) begin
      tx_data  = d;
      tx_valid = 1'b1;
    end
    @(negedge clk);
    if (keep) tx_data = nd;
    else      tx_valid = 1'b0;
    inh = 0;
    while (clk_oe && !data_oe && inh < INH + 20) begin
      inh++;
      @(negedge clk);
    end
    setup = 0;
    while (clk_oe && data_oe && setup < SETUP + 20) begin
      setup++;
      @(negedge clk);
    end
  endtask

  task automatic device_fall(output logic s);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    s = ps2_data_line;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_frame(input logic drive, input logic [7:0] d, input logic keep,
                          input logic [7:0] nd, input logic ack, output res_t r);
    int   d0, e0, n;
    logic s;
    d0 = done_cnt;
    e0 = err_cnt;
    begin_tx(drive, d, keep, nd, r.inh, r.setup);
    repeat (5) @(negedge clk);
    r.start = ps2_data_line;
    for (int i = 0; i < 10; i++) begin
      device_fall(s);
      r.bits[i] = s;
    end
    dev_data = ack;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    n = 0;
    while (busy && n < TO) begin
      @(negedge clk);
      n++;
    end
    r.idle_to = busy;
    r.dd = done_cnt - d0;
    r.de = err_cnt - e0;
  endtask

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r, r2;
    int   inh, setup, k, d0, e0;
    logic s;

    vecs[0] = '{data: 8'hF4, ack: 1'b0, par: 1'b0, exp_done: 1, exp_err: 0, exp_code: 2'b00};
    vecs[1] = '{data: 8'hFF, ack: 1'b0, par: 1'b1, exp_done: 1, exp_err: 0, exp_code: 2'b00};
    vecs[2] = '{data: 8'h00, ack: 1'b0, par: 1'b1, exp_done: 1, exp_err: 0, exp_code: 2'b00};
    vecs[3] = '{data: 8'h5A, ack: 1'b1, par: 1'b1, exp_done: 0, exp_err: 1, exp_code: 2'b01};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_done_err", {tx_done, tx_err}, 0);
    check("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", tx_ready, 1);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      do_frame(1'b1, vecs[i].data, 1'b0, 8'h00, vecs[i].ack, r);
      @(negedge clk);
      $display("vec %0d data=%02h bits=%b inh=%0d setup=%0d done=%0d err=%0d code=%b",
               i, vecs[i].data, r.bits, r.inh, r.setup, r.dd, r.de, err_code);
      check("inhibit_len", r.inh, INH);
      check("setup_len", r.setup, SETUP);
      check("start_bit", r.start, 0);
      check("data_bits", r.bits[7:0], vecs[i].data);
      check("parity_bit", r.bits[8], vecs[i].par);
      check("device_parity_ok", ^r.bits[8:0], 1);
      check("stop_bit", r.bits[9], 1);
      check("done_pulses", r.dd, vecs[i].exp_done);
      check("err_pulses", r.de, vecs[i].exp_err);
      check("err_code", err_code, vecs[i].exp_code);
      check("ready_after_pulse", ready_after, 1);
      check("busy_fell", r.idle_to, 0);
      if (vecs[i].exp_err != 0) check("oe_at_err", last_oe, 0);
    end

    // Timeout: device stops after the 4th fall edge
    d0 = done_cnt;
    e0 = err_cnt;
    begin_tx(1'b1, 8'h3C, 1'b0, 8'h00, inh, setup);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) device_fall(s);
    dev_clk = 1'b0;
    k = 0;
    while (!tx_err && k < TO + 100) begin
      @(negedge clk);
      k++;
      if (k == HALF) dev_clk = 1'b1;
    end
    $display("timeout: err after %0d cycles code=%b", k, err_code);
    check("timeout_latency", k, TO + 2);
    check("timeout_code", err_code, 2'b10);
    check("timeout_oe", {clk_oe, data_oe}, 0);
    check("timeout_no_done", tx_done, 0);
    @(negedge clk);
    check("timeout_ready", tx_ready, 1);
    check("timeout_code_hold", err_code, 2'b10);
    check("timeout_done_cnt", done_cnt - d0, 0);
    check("timeout_err_cnt", err_cnt - e0, 1);

    // Reset in the middle of SHIFT
    d0 = done_cnt;
    e0 = err_cnt;
    begin_tx(1'b1, 8'h00, 1'b0, 8'h00, inh, setup);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) device_fall(s);
    check("shift_data_oe", data_oe, 1);
    rst_n = 1'b0;
    #1;
    $display("mid-shift reset: clk_oe=%b data_oe=%b ready=%b", clk_oe, data_oe, tx_ready);
    check("arst_clk_oe", clk_oe, 0);
    check("arst_data_oe", data_oe, 0);
    check("arst_ready", tx_ready, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready_after", tx_ready, 1);
    check("arst_code", err_code, 0);
    check("arst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    do_frame(1'b1, 8'hF3, 1'b0, 8'h00, 1'b0, r);
    $display("after reset: data=F3 bits=%b done=%0d err=%0d", r.bits, r.dd, r.de);
    check("f3_bits", r.bits[7:0], 8'hF3);
    check("f3_parity", r.bits[8], 1);
    check("f3_done", r.dd, 1);
    check("f3_err", r.de, 0);
    @(negedge clk);

    // tx_valid held with new data during a transfer
    do_frame(1'b1, 8'hF4, 1'b1, 8'hAA, 1'b0, r);
    $display("held valid: first bits=%b done=%0d ready=%b", r.bits, r.dd, tx_ready);
    check("hold_first_bits", r.bits[7:0], 8'hF4);
    check("hold_first_done", r.dd, 1);
    check("hold_ready_idle", tx_ready, 1);
    do_frame(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r2);
    $display("held valid: second bits=%b inh=%0d done=%0d", r2.bits, r2.inh, r2.dd);
    check("hold_second_inh", r2.inh, INH);
    check("hold_second_bits", r2.bits[7:0], 8'hAA);
    check("hold_second_parity", r2.bits[8], 1);
    check("hold_second_done", r2.dd, 1);
    @(negedge clk);
    check("never_done_and_err", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
